// File: rtl/flip_sequencer.sv
// flip_sequencer: fetches candidate occurrence rows, strobes them into the flip selector, commits the chosen flip
module flip_sequencer #(
  parameter int NSAT = 3,
  parameter int MAX_CLAUSES_PER_VARIABLE = 20,
  parameter int NUM_VARS = 64,
  parameter int FLIP_CNT_BITS = 32,
  localparam int VB = $clog2(NUM_VARS),
  localparam int MC = MAX_CLAUSES_PER_VARIABLE
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NSAT*VB-1:0]       cand_vars_i,
  input  logic [NSAT-1:0]          cand_valid_i,
  input  logic                     cand_req_i,
  output logic                     cand_ack_o,
  output logic                     row_req_o,
  output logic [VB-1:0]            row_addr_o,
  input  logic                     row_valid_i,
  input  logic [MC-1:0]            row_broken_i,
  input  logic [MC-1:0]            row_mask_i,
  output logic [MC-1:0]            clause_broken_o,
  output logic [MC-1:0]            mask_bits_o,
  output logic [NSAT-1:0]          break_values_valid_o,
  output logic [1:0]               wr_en_o,
  input  logic [1:0]               selected_i,
  input  logic [MC-1:0]            clause_valid_bits_i,
  output logic                     flip_valid_o,
  input  logic                     flip_ready_i,
  output logic [VB-1:0]            flip_var_o,
  output logic [MC-1:0]            flip_clauses_o,
  output logic [NUM_VARS-1:0]      assignment_o,
  output logic [FLIP_CNT_BITS-1:0] flip_count_o,
  output logic                     done_o,
  output logic                     none_o
);
  typedef enum logic [2:0] {IDLE, FETCH, APPLY, SETTLE, COMMIT, DONE} state_t;
  state_t state;
  logic [1:0] n;
  logic [VB-1:0] vars [NSAT];
  logic [NSAT-1:0] vld;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      n <= '0;
      vld <= '0;
      for (int i = 0; i < NSAT; i++) vars[i] <= '0;
      cand_ack_o <= 1'b0;
      row_req_o <= 1'b0;
      row_addr_o <= '0;
      clause_broken_o <= '0;
      mask_bits_o <= '0;
      break_values_valid_o <= '0;
      wr_en_o <= '0;
      flip_valid_o <= 1'b0;
      flip_var_o <= '0;
      flip_clauses_o <= '0;
      assignment_o <= '0;
      flip_count_o <= '0;
      done_o <= 1'b0;
      none_o <= 1'b0;
    end else begin
      cand_ack_o <= 1'b0;
      case (state)
        IDLE: if (cand_req_i) begin
          for (int i = 0; i < NSAT; i++) vars[i] <= cand_vars_i[i*VB +: VB];
          vld <= cand_valid_i;
          cand_ack_o <= 1'b1;
          n <= '0;
          row_req_o <= cand_valid_i[0];
          row_addr_o <= cand_vars_i[VB-1:0];
          state <= FETCH;
        end
        // an invalid slot skips the memory and presents an empty row
        FETCH: if (!vld[n] || row_valid_i) begin
          row_req_o <= 1'b0;
          clause_broken_o <= vld[n] ? row_broken_i : '0;
          mask_bits_o <= vld[n] ? row_mask_i : '0;
          wr_en_o <= n + 2'd1;
          break_values_valid_o <= vld;
          state <= APPLY;
        end
        APPLY: begin
          wr_en_o <= '0;
          if (n == 2'd2) state <= SETTLE;
          else begin
            n <= n + 2'd1;
            row_req_o <= vld[n + 2'd1];
            row_addr_o <= vars[n + 2'd1];
            state <= FETCH;
          end
        end
        SETTLE: if (selected_i == 2'd3 || !vld[selected_i]) begin
          done_o <= 1'b1;
          none_o <= 1'b1;
          state <= DONE;
        end else begin
          flip_valid_o <= 1'b1;
          flip_var_o <= vars[selected_i];
          flip_clauses_o <= clause_valid_bits_i;
          state <= COMMIT;
        end
        COMMIT: if (flip_ready_i) begin
          assignment_o[flip_var_o] <= ~assignment_o[flip_var_o];
          flip_count_o <= flip_count_o + 1'b1;
          flip_valid_o <= 1'b0;
          done_o <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done_o <= 1'b0;
          none_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flip_sequencer.sv
// tb_flip_sequencer: directed checks of flip_sequencer with a latency-programmable row memory and ready stall
module tb_flip_sequencer;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [17:0] cand_vars_i = '0;
  logic [2:0] cand_valid_i = '0;
  logic cand_req_i = 1'b0;
  logic cand_ack_o, row_req_o, row_valid_i, flip_valid_o, flip_ready_i, done_o, none_o;
  logic [5:0] row_addr_o, flip_var_o;
  logic [19:0] row_broken_i, row_mask_i, clause_broken_o, mask_bits_o, flip_clauses_o;
  logic [19:0] clause_valid_bits_i = 20'hC3A5F;
  logic [2:0] break_values_valid_o;
  logic [1:0] wr_en_o;
  logic [1:0] selected_i = '0;
  logic [63:0] assignment_o;
  logic [31:0] flip_count_o;

  flip_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cand_vars_i(cand_vars_i), .cand_valid_i(cand_valid_i),
    .cand_req_i(cand_req_i), .cand_ack_o(cand_ack_o), .row_req_o(row_req_o), .row_addr_o(row_addr_o),
    .row_valid_i(row_valid_i), .row_broken_i(row_broken_i), .row_mask_i(row_mask_i),
    .clause_broken_o(clause_broken_o), .mask_bits_o(mask_bits_o),
    .break_values_valid_o(break_values_valid_o), .wr_en_o(wr_en_o), .selected_i(selected_i),
    .clause_valid_bits_i(clause_valid_bits_i), .flip_valid_o(flip_valid_o), .flip_ready_i(flip_ready_i),
    .flip_var_o(flip_var_o), .flip_clauses_o(flip_clauses_o), .assignment_o(assignment_o),
    .flip_count_o(flip_count_o), .done_o(done_o), .none_o(none_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [19:0] brk(input logic [5:0] a);
    return {a, 14'h05A};
  endfunction

  int lat = 1, rd = 0, mcnt = 0, fv_cnt = 0, cyc = 0;
  initial row_valid_i = 1'b0;
  assign row_broken_i = brk(row_addr_o);
  assign row_mask_i = ~brk(row_addr_o);
  assign flip_ready_i = flip_valid_o && fv_cnt >= rd;

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    fv_cnt <= flip_valid_o ? fv_cnt + 1 : 0;
    if (!row_req_o || row_valid_i) begin
      mcnt <= 0;
      row_valid_i <= 1'b0;
    end else begin
      mcnt <= mcnt + 1;
      row_valid_i <= (mcnt + 1 == lat);
    end
  end

  logic [1:0] wr_log [8];
  logic [19:0] brk_log [8];
  int wr_n, req_n, viol, fv_cyc, ack_n, done_n, ack_cyc, done_cyc;
  logic none_s, p_req, p_rv, p_fv, p_fr;
  logic [5:0] p_addr, p_var, fv_var;
  logic [19:0] p_cl, fv_cl;

  always @(negedge clk_i) begin
    if (wr_en_o != 2'd0 && wr_n < 8) begin
      wr_log[wr_n] = wr_en_o;
      brk_log[wr_n] = clause_broken_o;
      wr_n++;
    end
    if (row_req_o && !p_req) req_n++;
    if (p_req && row_req_o && row_addr_o != p_addr) viol++;
    if (p_req && !p_rv && !row_req_o && rst_ni) viol++;
    if (p_fv && flip_valid_o && (flip_var_o != p_var || flip_clauses_o != p_cl)) viol++;
    if (p_fv && !p_fr && !flip_valid_o && rst_ni) viol++;
    if (flip_valid_o) begin
      fv_cyc++;
      fv_var = flip_var_o;
      fv_cl = flip_clauses_o;
    end
    if (cand_ack_o) begin
      ack_n++;
      ack_cyc = cyc;
    end
    if (done_o) begin
      done_n++;
      none_s = none_o;
      done_cyc = cyc;
    end
    p_req = row_req_o; p_addr = row_addr_o; p_rv = row_valid_i;
    p_fv = flip_valid_o; p_fr = flip_ready_i; p_var = flip_var_o; p_cl = flip_clauses_o;
  end

  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wr_n = 0; req_n = 0; viol = 0; fv_cyc = 0; ack_n = 0; done_n = 0;
    ack_cyc = 0; done_cyc = 0; none_s = 1'bx; fv_var = 'x; fv_cl = 'x;
    for (int i = 0; i < 8; i++) begin
      wr_log[i] = '0;
      brk_log[i] = '0;
    end
  endtask

  task automatic start_set(input logic [5:0] v0, v1, v2, input logic [2:0] vl,
                           input logic [1:0] sel, input int l, input int r);
    logic got;
    got = 1'b0;
    lat = l; rd = r; selected_i = sel;
    cand_vars_i = {v2, v1, v0};
    cand_valid_i = vl;
    clear_logs();
    cand_req_i = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk_i);
      got = cand_ack_o;
    end
    cand_req_i = 1'b0;
    chk("ack_seen", {63'd0, got}, 64'd1);
  endtask

  task automatic wait_done();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk_i);
      got = done_o;
    end
    chk("done_seen", {63'd0, got}, 64'd1);
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    logic got;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_ack", {63'd0, cand_ack_o}, 64'd0);
    chk("rst_req", {63'd0, row_req_o}, 64'd0);
    chk("rst_wr_en", {62'd0, wr_en_o}, 64'd0);
    chk("rst_done", {63'd0, done_o}, 64'd0);
    chk("rst_count", {32'd0, flip_count_o}, 64'd0);

    // reset while a flip commit is waiting for ready
    start_set(6'd5, 6'd9, 6'd12, 3'b111, 2'd1, 1, 1000);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk_i);
      got = flip_valid_o;
    end
    chk("t1_fv_seen", {63'd0, got}, 64'd1);
    repeat (2) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("t1_fv", {63'd0, flip_valid_o}, 64'd0);
    chk("t1_var", {58'd0, flip_var_o}, 64'd0);
    chk("t1_clauses", {44'd0, flip_clauses_o}, 64'd0);
    chk("t1_asg", assignment_o, 64'd0);
    chk("t1_count", {32'd0, flip_count_o}, 64'd0);
    chk("t1_bvv", {61'd0, break_values_valid_o}, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    rd = 0;
    repeat (2) @(negedge clk_i);

    // vars {5,9,12}, selector picks slot 1
    start_set(6'd5, 6'd9, 6'd12, 3'b111, 2'd1, 1, 0);
    wait_done();
    chk("t2_wr_n", wr_n, 3);
    chk("t2_wr0", {62'd0, wr_log[0]}, 64'd1);
    chk("t2_wr1", {62'd0, wr_log[1]}, 64'd2);
    chk("t2_wr2", {62'd0, wr_log[2]}, 64'd3);
    chk("t2_row0", {44'd0, brk_log[0]}, {44'd0, brk(6'd5)});
    chk("t2_row1", {44'd0, brk_log[1]}, {44'd0, brk(6'd9)});
    chk("t2_row2", {44'd0, brk_log[2]}, {44'd0, brk(6'd12)});
    chk("t2_mask", {44'd0, mask_bits_o}, {44'd0, ~brk(6'd12)});
    chk("t2_bvv", {61'd0, break_values_valid_o}, 64'd7);
    chk("t2_req_n", req_n, 3);
    chk("t2_var", {58'd0, fv_var}, 64'd9);
    chk("t2_clauses", {44'd0, fv_cl}, 64'hC3A5F);
    chk("t2_fv_cyc", fv_cyc, 1);
    chk("t2_asg", assignment_o, 64'h200);
    chk("t2_count", {32'd0, flip_count_o}, 64'd1);
    chk("t2_none", {63'd0, none_s}, 64'd0);
    chk("t2_latency", done_cyc - ack_cyc, 11);

    // same set again toggles var 9 back
    start_set(6'd5, 6'd9, 6'd12, 3'b111, 2'd1, 1, 0);
    wait_done();
    chk("t3_asg", assignment_o, 64'd0);
    chk("t3_count", {32'd0, flip_count_o}, 64'd2);
    chk("t3_done_n", done_n, 1);

    // slot 1 absent, selector picks slot 2
    start_set(6'd5, 6'd9, 6'd12, 3'b101, 2'd2, 1, 0);
    wait_done();
    chk("t4_req_n", req_n, 2);
    chk("t4_wr_n", wr_n, 3);
    chk("t4_row0", {44'd0, brk_log[0]}, {44'd0, brk(6'd5)});
    chk("t4_row1", {44'd0, brk_log[1]}, 64'd0);
    chk("t4_row2", {44'd0, brk_log[2]}, {44'd0, brk(6'd12)});
    chk("t4_bvv", {61'd0, break_values_valid_o}, 64'd5);
    chk("t4_var", {58'd0, fv_var}, 64'd12);
    chk("t4_asg", assignment_o, 64'h1000);
    chk("t4_count", {32'd0, flip_count_o}, 64'd3);
    chk("t4_none", {63'd0, none_s}, 64'd0);

    // no valid candidates
    start_set(6'd7, 6'd8, 6'd10, 3'b000, 2'd0, 1, 0);
    wait_done();
    chk("t5_wr_n", wr_n, 3);
    chk("t5_wr2", {62'd0, wr_log[2]}, 64'd3);
    chk("t5_row0", {44'd0, brk_log[0]}, 64'd0);
    chk("t5_req_n", req_n, 0);
    chk("t5_fv_cyc", fv_cyc, 0);
    chk("t5_none", {63'd0, none_s}, 64'd1);
    chk("t5_asg", assignment_o, 64'h1000);
    chk("t5_count", {32'd0, flip_count_o}, 64'd3);

    // slow memory, stalled commit, request while busy
    start_set(6'd1, 6'd2, 6'd3, 3'b111, 2'd0, 4, 5);
    repeat (3) @(negedge clk_i);
    cand_req_i = 1'b1;
    repeat (3) @(negedge clk_i);
    cand_req_i = 1'b0;
    wait_done();
    chk("t6_stable", viol, 0);
    chk("t6_ack_n", ack_n, 1);
    chk("t6_req_n", req_n, 3);
    chk("t6_fv_cyc", fv_cyc, 6);
    chk("t6_var", {58'd0, fv_var}, 64'd1);
    chk("t6_asg", assignment_o, 64'h1002);
    chk("t6_count", {32'd0, flip_count_o}, 64'd4);
    chk("t6_none", {63'd0, none_s}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
